alu_pipe_unit: RTL and testbench
================================

Name: alu_pipe_unit

Overview:
Parametrised, pipelined integer ALU execution unit that sits between a reservation station and the writeback/CDB arbiter. It takes one reservation_station_t per cycle under a valid/ready handshake and computes the ALU result. The result passes through STAGES register stages with full backpressure from writeback. A flush discards all in-flight ops on mispredict.

Parameters:
STAGES, 2, number of result register stages (legal 1..4); latency from accept to output-valid = STAGES cycles.
ZERO_X0, 1, when 1, ops with rd_addr==0 leave with regf_we=0 and rd_data=0.

Ports:
clk  input  1  clock, all state on posedge.
rst  input  1  synchronous, active-high reset.
flush  input  1  discard every in-flight op and any op offered this cycle.
next_execute  input  reservation_station_t  issued op; .valid is the request.
ready  output  1  unit accepts next_execute this cycle.
execute_output  output  to_writeback_t  result; .valid is the offer.
wb_ready  input  1  writeback consumes execute_output this cycle.
busy  output  1  any stage holds a valid op.

Behaviour:
- Operand select, from rv32i_types enums:
  - alu_m1_sel: rs1_out gives rs1_data; pc_out gives pc; anything else gives 0.
  - alu_m2_sel: rs2_out gives rs2_data; imm_out gives imm_sext; four_out gives 4; anything else gives 0.
- Ops, 32-bit, wrap-around add/sub:
  - add, sub, xor, or, and.
  - sll, srl, sra: shift amount is b[4:0]; sra is arithmetic.
  - slt signed, sltu unsigned: result 1 or 0.
  - unknown aluop gives 0.
- Result computed combinationally from next_execute and captured into stage 0 on accept.
- Accept = next_execute.valid && ready && !flush.
- Stage k holds valid_k plus payload: pc, rd_addr, rs1_addr, rs2_addr, rd_rob_idx, regf_we, rd_data.
- Stage k advances into k+1 when k+1 is empty or k+1 is itself advancing. The last stage advances when wb_ready is high.
- ready = stage 0 empty or stage 0 advancing; combinational, and forced to 0 while rst or flush is high.
- Throughput: 1 op/cycle when wb_ready is held high. Latency is exactly STAGES cycles; with STAGES=1 the result is visible the cycle after accept.
- execute_output = last stage. While execute_output.valid && !wb_ready, every field holds stable and nothing is lost. Fields are '0 when invalid.
- busy = OR of all stage valid bits.
- Backpressure example: all stages full and wb_ready=0 gives ready=0. One wb_ready pulse shifts the whole pipe by one and raises ready in the same cycle.
- Flush: at the next edge all valid bits clear. The op offered in the flush cycle is not accepted. flush wins over wb_ready; the output shown in the flush cycle counts as not consumed.
- Reset: at the next edge all valid bits clear. Afterwards execute_output='0, busy=0, ready=1. Reset mid-operation drops all ops; payload registers need not reset.
- ZERO_X0=1 and rd_addr==0: rd_data=0 and regf_we=0 at output; the op still retires (rob idx delivered).
- Simultaneous accept and output consume with a full pipe is legal and keeps occupancy constant.

Decomposition:
- rv32i_types package holds:
  - existing: reservation_station_t, to_writeback_t, the alu_ops enum, alu_m1_sel/alu_m2_sel enums;
  - new: typedef alu_stage_t (valid + to_writeback_t payload).
- One natural combinational sub-module: alu_core, covering operand mux and op decode, with inputs next_execute and output aluout[31:0].
- alu_pipe_unit owns the stage array (generate loop over STAGES), the handshake, flush and reset.

Test Plan:
- STAGES=2, wb_ready=1, add rs1=0x7FFFFFFF rs2=1 rob 3 -> after 2 cycles valid=1, rd_data=0x80000000, rd_rob_idx=3; one beat only.
- Back-to-back sub 5-7, sra 0x80000000>>4, sltu 1<0xFFFFFFFF on consecutive cycles -> outputs 0xFFFFFFFE, 0xF8000000, 1 on consecutive cycles; ready stays 1.
- wb_ready=0 for 5 cycles while issuing 3 ops -> ready drops after 2 accepts (STAGES=2); output holds first result stable; releasing wb_ready drains results in issue order with none lost.
- flush with 2 ops in flight and a third offered -> next cycle busy=0, execute_output.valid=0; third op never appears.
- ZERO_X0=1, addi rd=0 imm=5 -> output valid=1, regf_we=0, rd_data=0; rs1_out with rd=1 gives rd_data=rs1+5 and regf_we passed through.
- rst held 1 cycle mid-stream with full pipe -> next cycle valid=0, busy=0, ready=1; ready=0 during the reset cycle; repeat with STAGES=1 and STAGES=4 for latency 1 and 4.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared RV32I execution types: issue/writeback payloads, ALU op and operand-select encodings.
package rv32i_types;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned ROB_IDX_W  = 4;

  typedef enum logic [3:0] {
    alu_add  = 4'd0,
    alu_sll  = 4'd1,
    alu_sra  = 4'd2,
    alu_sub  = 4'd3,
    alu_xor  = 4'd4,
    alu_srl  = 4'd5,
    alu_or   = 4'd6,
    alu_and  = 4'd7,
    alu_slt  = 4'd8,
    alu_sltu = 4'd9
  } alu_ops;

  typedef enum logic [1:0] {
    rs1_out = 2'd0,
    pc_out  = 2'd1
  } alu_m1_sel_t;

  typedef enum logic [1:0] {
    rs2_out  = 2'd0,
    imm_out  = 2'd1,
    four_out = 2'd2
  } alu_m2_sel_t;

  typedef struct packed {
    logic                  valid;
    logic [XLEN-1:0]       pc;
    logic [REG_ADDR_W-1:0] rd_addr;
    logic [REG_ADDR_W-1:0] rs1_addr;
    logic [REG_ADDR_W-1:0] rs2_addr;
    logic [ROB_IDX_W-1:0]  rd_rob_idx;
    logic                  regf_we;
    alu_ops                aluop;
    alu_m1_sel_t           alu_m1_sel;
    alu_m2_sel_t           alu_m2_sel;
    logic [XLEN-1:0]       rs1_data;
    logic [XLEN-1:0]       rs2_data;
    logic [XLEN-1:0]       imm_sext;
  } reservation_station_t;

  typedef struct packed {
    logic                  valid;
    logic [XLEN-1:0]       pc;
    logic [REG_ADDR_W-1:0] rd_addr;
    logic [REG_ADDR_W-1:0] rs1_addr;
    logic [REG_ADDR_W-1:0] rs2_addr;
    logic [ROB_IDX_W-1:0]  rd_rob_idx;
    logic                  regf_we;
    logic [XLEN-1:0]       rd_data;
  } to_writeback_t;

  // One pipeline slot: occupancy bit plus the result it carries.
  typedef struct packed {
    logic          valid;
    to_writeback_t wb;
  } alu_stage_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: operand selection and op decode for one issued instruction.
module alu_core
  import rv32i_types::*;
(
  input  alu_ops          i_aluop,
  input  alu_m1_sel_t     i_m1_sel,
  input  alu_m2_sel_t     i_m2_sel,
  input  logic [XLEN-1:0] i_rs1_data,
  input  logic [XLEN-1:0] i_rs2_data,
  input  logic [XLEN-1:0] i_imm_sext,
  input  logic [XLEN-1:0] i_pc,
  output logic [XLEN-1:0] o_aluout
);

  logic [XLEN-1:0] w_a;
  logic [XLEN-1:0] w_b;

  // Operand muxes; unlisted select encodings feed zero.
  always_comb begin
    w_a = '0;
    w_b = '0;
    case (i_m1_sel)
      rs1_out: w_a = i_rs1_data;
      pc_out:  w_a = i_pc;
      default: w_a = '0;
    endcase
    case (i_m2_sel)
      rs2_out:  w_b = i_rs2_data;
      imm_out:  w_b = i_imm_sext;
      four_out: w_b = XLEN'(4);
      default:  w_b = '0;
    endcase
  end

  // Op decode; shifts use only the low five bits of b, unknown ops give zero.
  always_comb begin
    o_aluout = '0;
    case (i_aluop)
      alu_add:  o_aluout = w_a + w_b;
      alu_sub:  o_aluout = w_a - w_b;
      alu_xor:  o_aluout = w_a ^ w_b;
      alu_or:   o_aluout = w_a | w_b;
      alu_and:  o_aluout = w_a & w_b;
      alu_sll:  o_aluout = w_a << w_b[4:0];
      alu_srl:  o_aluout = w_a >> w_b[4:0];
      alu_sra:  o_aluout = XLEN'($signed(w_a) >>> w_b[4:0]);
      alu_slt:  o_aluout = XLEN'($signed(w_a) < $signed(w_b));
      alu_sltu: o_aluout = XLEN'(w_a < w_b);
      default:  o_aluout = '0;
    endcase
  end

endmodule

// File: rtl/alu_pipe_unit.sv
// Pipelined ALU execution unit: valid/ready issue, STAGES result slots with full
// backpressure from writeback, flush and synchronous reset drop all in-flight ops.
module alu_pipe_unit
  import rv32i_types::*;
#(
  parameter int unsigned STAGES  = 2,
  parameter bit          ZERO_X0 = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  reservation_station_t next_execute,
  output logic                 ready,
  output to_writeback_t        execute_output,
  input  logic                 wb_ready,
  output logic                 busy
);

  localparam int unsigned LAST = STAGES - 1;

  logic [XLEN-1:0]   w_aluout;
  logic              w_accept;
  to_writeback_t     w_in_wb;
  logic [STAGES-1:0] w_valid;
  logic [STAGES-1:0] w_free;
  alu_stage_t        r_stage [STAGES];

  alu_core u_alu_core (
    .i_aluop    (next_execute.aluop),
    .i_m1_sel   (next_execute.alu_m1_sel),
    .i_m2_sel   (next_execute.alu_m2_sel),
    .i_rs1_data (next_execute.rs1_data),
    .i_rs2_data (next_execute.rs2_data),
    .i_imm_sext (next_execute.imm_sext),
    .i_pc       (next_execute.pc),
    .o_aluout   (w_aluout)
  );

  // Build the stage-0 payload; writes to x0 retire without touching the register file.
  always_comb begin
    w_in_wb            = '0;
    w_in_wb.pc         = next_execute.pc;
    w_in_wb.rd_addr    = next_execute.rd_addr;
    w_in_wb.rs1_addr   = next_execute.rs1_addr;
    w_in_wb.rs2_addr   = next_execute.rs2_addr;
    w_in_wb.rd_rob_idx = next_execute.rd_rob_idx;
    w_in_wb.regf_we    = next_execute.regf_we;
    w_in_wb.rd_data    = w_aluout;
    if (ZERO_X0 && (next_execute.rd_addr == '0)) begin
      w_in_wb.regf_we = 1'b0;
      w_in_wb.rd_data = '0;
    end
  end

  assign ready    = w_free[0] & ~rst & ~flush;
  assign w_accept = next_execute.valid & ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    alu_stage_t w_src;

    assign w_valid[k] = r_stage[k].valid;
    // A slot can load when some slot from here to the tail is empty, or writeback drains the tail.
    assign w_free[k]  = wb_ready | ~(&w_valid[LAST:k]);

    if (k == 0) begin : g_head
      assign w_src = '{valid: w_accept, wb: w_in_wb};
    end else begin : g_body
      assign w_src = r_stage[k-1];
    end

    // Slot register: cleared by reset/flush, loads from upstream when free, otherwise holds.
    always_ff @(posedge clk) begin
      if (rst || flush) begin
        r_stage[k].valid <= 1'b0;
      end else if (w_free[k]) begin
        r_stage[k] <= w_src;
      end
    end
  end

  // Present the tail slot; all fields read as zero when it is empty.
  always_comb begin
    execute_output = '0;
    if (w_valid[LAST]) begin
      execute_output       = r_stage[LAST].wb;
      execute_output.valid = 1'b1;
    end
  end

  assign busy = |w_valid;

endmodule

// File: tb/tb_alu_pipe_unit.sv
// Self-checking bench for alu_pipe_unit: vector table plus hand-written corner sequences.
module tb_alu_pipe_unit;
  import rv32i_types::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, flush, wb_ready;
  reservation_station_t nx;
  to_writeback_t out1, out2, out4;
  logic ready1, ready2, ready4, busy1, busy2, busy4;

  alu_pipe_unit #(.STAGES(2), .ZERO_X0(1'b1)) dut2 (
    .clk(clk), .rst(rst), .flush(flush), .next_execute(nx), .ready(ready2),
    .execute_output(out2), .wb_ready(wb_ready), .busy(busy2));
  alu_pipe_unit #(.STAGES(1), .ZERO_X0(1'b1)) dut1 (
    .clk(clk), .rst(rst), .flush(flush), .next_execute(nx), .ready(ready1),
    .execute_output(out1), .wb_ready(wb_ready), .busy(busy1));
  alu_pipe_unit #(.STAGES(4), .ZERO_X0(1'b1)) dut4 (
    .clk(clk), .rst(rst), .flush(flush), .next_execute(nx), .ready(ready4),
    .execute_output(out4), .wb_ready(wb_ready), .busy(busy4));

  int n_checks = 0;
  int n_errors = 0;
  to_writeback_t q[$];
  to_writeback_t cur_exp;

  typedef struct {
    alu_ops      op;
    alu_m1_sel_t m1;
    alu_m2_sel_t m2;
    logic [31:0] a, b, imm, pc, exp;
  } vec_t;
  vec_t vecs[18];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, got, exp);
    end
  endtask

  task automatic chkb(input string name, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b required %b", name, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input alu_ops op, input alu_m1_sel_t m1,
                                        input alu_m2_sel_t m2, input logic [31:0] rs1,
                                        input logic [31:0] rs2, input logic [31:0] imm,
                                        input logic [31:0] pc);
    logic [31:0] a, b;
    a = (m1 == rs1_out) ? rs1 : (m1 == pc_out) ? pc : 32'd0;
    b = (m2 == rs2_out) ? rs2 : (m2 == imm_out) ? imm : (m2 == four_out) ? 32'd4 : 32'd0;
    case (op)
      alu_add:  return a + b;
      alu_sub:  return a - b;
      alu_xor:  return a ^ b;
      alu_or:   return a | b;
      alu_and:  return a & b;
      alu_sll:  return a << b[4:0];
      alu_srl:  return a >> b[4:0];
      alu_sra:  return 32'($signed(a) >>> b[4:0]);
      alu_slt:  return {31'd0, $signed(a) < $signed(b)};
      alu_sltu: return {31'd0, a < b};
      default:  return 32'd0;
    endcase
  endfunction

  task automatic set_op(input alu_ops op, input alu_m1_sel_t m1, input alu_m2_sel_t m2,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                        input logic [31:0] pc, input logic [4:0] rd, input logic [3:0] rob);
    nx            = '0;
    nx.valid      = 1'b1;
    nx.pc         = pc;
    nx.rd_addr    = rd;
    nx.rs1_addr   = 5'd2;
    nx.rs2_addr   = 5'd3;
    nx.rd_rob_idx = rob;
    nx.regf_we    = 1'b1;
    nx.aluop      = op;
    nx.alu_m1_sel = m1;
    nx.alu_m2_sel = m2;
    nx.rs1_data   = a;
    nx.rs2_data   = b;
    nx.imm_sext   = imm;
    cur_exp            = '0;
    cur_exp.valid      = 1'b1;
    cur_exp.pc         = pc;
    cur_exp.rd_addr    = rd;
    cur_exp.rs1_addr   = 5'd2;
    cur_exp.rs2_addr   = 5'd3;
    cur_exp.rd_rob_idx = rob;
    cur_exp.regf_we    = (rd != 5'd0);
    cur_exp.rd_data    = (rd != 5'd0) ? model(op, m1, m2, a, b, imm, pc) : 32'd0;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard for the STAGES=2 unit: push on accept, pop on consume, drop on reset/flush.
  always @(negedge clk) begin
    if (rst || flush) begin
      q.delete();
    end else begin
      if (out2.valid && wb_ready) begin
        if (q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL sb_unexpected: got beat rob %0d, required no beat", out2.rd_rob_idx);
        end else begin
          to_writeback_t e;
          e = q.pop_front();
          chk("sb_rd_data", out2.rd_data, e.rd_data);
          chk("sb_rob", 32'(out2.rd_rob_idx), 32'(e.rd_rob_idx));
          chkb("sb_regf_we", out2.regf_we, e.regf_we);
          chk("sb_rd_addr", 32'(out2.rd_addr), 32'(e.rd_addr));
          chk("sb_pc", out2.pc, e.pc);
        end
      end
      if (nx.valid && ready2) q.push_back(cur_exp);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    to_writeback_t exp_a;

    vecs[0]  = '{alu_sub,  rs1_out, rs2_out, 32'd5,        32'd7,        32'd0, 32'h0, 32'hFFFFFFFE};
    vecs[1]  = '{alu_sra,  rs1_out, rs2_out, 32'h80000000, 32'd4,        32'd0, 32'h4, 32'hF8000000};
    vecs[2]  = '{alu_sltu, rs1_out, rs2_out, 32'd1,        32'hFFFFFFFF, 32'd0, 32'h8, 32'd1};
    vecs[3]  = '{alu_add,  rs1_out, rs2_out, 32'hFFFFFFFF, 32'd2,        32'd0, 32'hC, 32'd1};
    vecs[4]  = '{alu_xor,  rs1_out, rs2_out, 32'hF0F0F0F0, 32'hFF00FF00, 32'd0, 32'h10, 32'h0FF00FF0};
    vecs[5]  = '{alu_or,   rs1_out, rs2_out, 32'h12340000, 32'h00005678, 32'd0, 32'h14, 32'h12345678};
    vecs[6]  = '{alu_and,  rs1_out, rs2_out, 32'hF0F0F0F0, 32'h3C3C3C3C, 32'd0, 32'h18, 32'h30303030};
    vecs[7]  = '{alu_sll,  rs1_out, rs2_out, 32'd1,        32'h3F,       32'd0, 32'h1C, 32'h80000000};
    vecs[8]  = '{alu_srl,  rs1_out, rs2_out, 32'h80000000, 32'h24,       32'd0, 32'h20, 32'h08000000};
    vecs[9]  = '{alu_slt,  rs1_out, rs2_out, 32'hFFFFFFFF, 32'd1,        32'd0, 32'h24, 32'd1};
    vecs[10] = '{alu_slt,  rs1_out, rs2_out, 32'd1,        32'hFFFFFFFF, 32'd0, 32'h28, 32'd0};
    vecs[11] = '{alu_sltu, rs1_out, rs2_out, 32'hFFFFFFFF, 32'd1,        32'd0, 32'h2C, 32'd0};
    vecs[12] = '{alu_ops'(4'hF), rs1_out, rs2_out, 32'd5,  32'd6,        32'd0, 32'h30, 32'd0};
    vecs[13] = '{alu_add,  pc_out,  four_out, 32'h55,      32'h77,       32'd0, 32'h100, 32'h104};
    vecs[14] = '{alu_add,  alu_m1_sel_t'(2'd3), imm_out, 32'h55, 32'h77, 32'd9, 32'h34, 32'd9};
    vecs[15] = '{alu_add,  rs1_out, alu_m2_sel_t'(2'd3), 32'h21, 32'h99, 32'd0, 32'h38, 32'h21};
    vecs[16] = '{alu_sub,  rs1_out, imm_out, 32'd10,       32'h77,       32'd3, 32'h3C, 32'd7};
    vecs[17] = '{alu_sra,  rs1_out, rs2_out, 32'h7FFFFFF0, 32'd4,        32'd0, 32'h40, 32'h07FFFFFF};

    rst = 1'b1; flush = 1'b0; wb_ready = 1'b1; nx = '0; cur_exp = '0;
    tick; tick;
    rst = 1'b0;
    #1;
    chkb("reset_ready", ready2, 1'b1);
    chkb("reset_busy", busy2, 1'b0);
    chkb("reset_valid", out2.valid, 1'b0);
    chk("reset_out_zero", out2.rd_data, 32'd0);

    // Single add: latency 1/2/4 on the three units, one beat only.
    set_op(alu_add, rs1_out, rs2_out, 32'h7FFFFFFF, 32'd1, 32'd0, 32'h40, 5'd5, 4'd3);
    tick; nx.valid = 1'b0;
    chkb("lat1_valid", out1.valid, 1'b1);
    chk("lat1_data", out1.rd_data, 32'h80000000);
    chkb("lat2_not_yet", out2.valid, 1'b0);
    tick;
    chkb("lat2_valid", out2.valid, 1'b1);
    chk("lat2_data", out2.rd_data, 32'h80000000);
    chk("lat2_rob", 32'(out2.rd_rob_idx), 32'd3);
    tick;
    chkb("lat2_one_beat", out2.valid, 1'b0);
    chkb("lat4_not_yet", out4.valid, 1'b0);
    tick;
    chkb("lat4_valid", out4.valid, 1'b1);
    chk("lat4_data", out4.rd_data, 32'h80000000);
    tick;

    // Back-to-back table vectors at full throughput.
    for (int i = 0; i < 18; i++) begin
      set_op(vecs[i].op, vecs[i].m1, vecs[i].m2, vecs[i].a, vecs[i].b, vecs[i].imm,
             vecs[i].pc, 5'd1, 4'(i));
      cur_exp.rd_data = vecs[i].exp;
      chkb("b2b_ready", ready2, 1'b1);
      if (i >= 2) chkb("b2b_out_valid", out2.valid, 1'b1);
      tick;
    end
    nx.valid = 1'b0;
    repeat (4) tick;
    chk("b2b_drained", 32'(q.size()), 32'd0);

    // Backpressure: two accepts fill the pipe, the head result holds until released.
    wb_ready = 1'b0;
    set_op(alu_add, rs1_out, imm_out, 32'd100, 32'd0, 32'd23, 32'h200, 5'd4, 4'd1);
    exp_a = cur_exp;
    chkb("bp_ready_a", ready2, 1'b1);
    tick;
    set_op(alu_xor, rs1_out, rs2_out, 32'hAAAA5555, 32'hFFFF0000, 32'd0, 32'h204, 5'd6, 4'd2);
    chkb("bp_ready_b", ready2, 1'b1);
    tick;
    set_op(alu_sll, rs1_out, imm_out, 32'd3, 32'd0, 32'd8, 32'h208, 5'd7, 4'd4);
    chkb("bp_ready_low", ready2, 1'b0);
    repeat (3) begin
      chkb("bp_hold_valid", out2.valid, 1'b1);
      chk("bp_hold_data", out2.rd_data, exp_a.rd_data);
      chk("bp_hold_rob", 32'(out2.rd_rob_idx), 32'(exp_a.rd_rob_idx));
      tick;
      chkb("bp_still_low", ready2, 1'b0);
    end
    wb_ready = 1'b1;
    #1;
    chkb("bp_ready_release", ready2, 1'b1);
    tick;
    nx.valid = 1'b0;
    repeat (4) tick;
    chk("bp_drained", 32'(q.size()), 32'd0);

    // Flush with two in flight and a third offered.
    set_op(alu_add, rs1_out, rs2_out, 32'd1, 32'd2, 32'd0, 32'h300, 5'd8, 4'd5);
    tick;
    set_op(alu_add, rs1_out, rs2_out, 32'd3, 32'd4, 32'd0, 32'h304, 5'd9, 4'd6);
    tick;
    set_op(alu_add, rs1_out, rs2_out, 32'd5, 32'd6, 32'd0, 32'h308, 5'd10, 4'd7);
    flush = 1'b1;
    #1;
    chkb("flush_ready_low", ready2, 1'b0);
    chkb("flush_busy_before", busy2, 1'b1);
    tick;
    flush = 1'b0; nx.valid = 1'b0;
    chkb("flush_busy", busy2, 1'b0);
    chkb("flush_valid", out2.valid, 1'b0);
    repeat (3) begin
      tick;
      chkb("flush_no_ghost", out2.valid, 1'b0);
    end
    chk("flush_queue", 32'(q.size()), 32'd0);

    // Writes to x0 retire with regf_we=0 and zero data.
    set_op(alu_add, rs1_out, imm_out, 32'd10, 32'h99, 32'd5, 32'h400, 5'd0, 4'd9);
    tick;
    set_op(alu_add, rs1_out, imm_out, 32'd10, 32'h99, 32'd5, 32'h404, 5'd1, 4'd10);
    tick;
    nx.valid = 1'b0;
    chkb("x0_valid", out2.valid, 1'b1);
    chkb("x0_we", out2.regf_we, 1'b0);
    chk("x0_data", out2.rd_data, 32'd0);
    chk("x0_rob", 32'(out2.rd_rob_idx), 32'd9);
    tick;
    chkb("x1_we", out2.regf_we, 1'b1);
    chk("x1_data", out2.rd_data, 32'd15);
    tick;

    // Reset with full pipes on all three depths.
    wb_ready = 1'b0;
    set_op(alu_or, rs1_out, rs2_out, 32'h1, 32'h2, 32'd0, 32'h500, 5'd3, 4'd11);
    repeat (5) tick;
    chkb("full_ready2", ready2, 1'b0);
    chkb("full_ready4", ready4, 1'b0);
    chkb("full_busy2", busy2, 1'b1);
    rst = 1'b1;
    #1;
    chkb("rst_cycle_ready1", ready1, 1'b0);
    chkb("rst_cycle_ready2", ready2, 1'b0);
    chkb("rst_cycle_ready4", ready4, 1'b0);
    tick;
    rst = 1'b0; nx.valid = 1'b0;
    #1;
    chkb("post_rst_valid1", out1.valid, 1'b0);
    chkb("post_rst_valid2", out2.valid, 1'b0);
    chkb("post_rst_valid4", out4.valid, 1'b0);
    chkb("post_rst_busy1", busy1, 1'b0);
    chkb("post_rst_busy2", busy2, 1'b0);
    chkb("post_rst_busy4", busy4, 1'b0);
    chkb("post_rst_ready1", ready1, 1'b1);
    chkb("post_rst_ready2", ready2, 1'b1);
    chkb("post_rst_ready4", ready4, 1'b1);
    wb_ready = 1'b1;
    tick;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
